// File: rtl/sensor_filter.sv
// sensor_filter: synchronise, prescale-sample and debounce the three IR line sensors.
// Build with LINE_LOST_EN defined to add the lost-line counter behind line_lost.
module sensor_filter #(
  parameter int TICK_DIV   = 50000,
  parameter int CNT_MAX    = 7,
  parameter int LOST_TICKS = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sensorLeftRaw,
  input  logic sensorMiddleRaw,
  input  logic sensorRightRaw,
  output logic sensorLeftFiltered,
  output logic sensorMiddleFiltered,
  output logic sensorRightFiltered,
  output logic sample_tick,
  output logic changed,
  output logic line_lost
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int IW = $clog2(CNT_MAX + 1);
  localparam logic [TW-1:0] TLAST = TW'(TICK_DIV - 1);
  localparam logic [IW-1:0] CMAX = IW'(CNT_MAX);
  logic [2:0] raw, s1_q, s2_q, filt_q, filt_d;
  logic [IW-1:0] cnt_q [3];
  logic [IW-1:0] cnt_d [3];
  logic [TW-1:0] div_q, div_d;
  logic tick_q, tick_d, changed_q, changed_d;
  assign raw = {sensorLeftRaw, sensorMiddleRaw, sensorRightRaw};
  always_comb begin
    div_d = div_q == TLAST ? '0 : div_q + 1'b1;
    tick_d = div_q == TLAST;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick_q && s2_q[i] && cnt_q[i] != CMAX) cnt_d[i] = cnt_q[i] + 1'b1;
      else if (tick_q && !s2_q[i] && cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
      // only the saturation points move the output; intermediate counts hold it
      filt_d[i] = cnt_d[i] == CMAX ? 1'b1 : cnt_d[i] == '0 ? 1'b0 : filt_q[i];
    end
    changed_d = filt_d != filt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
      cnt_q <= '{default: CMAX};
      filt_q <= '1;
      div_q <= '0;
      tick_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      filt_q <= filt_d;
      div_q <= div_d;
      tick_q <= tick_d;
      changed_q <= changed_d;
    end
  end
  assign {sensorLeftFiltered, sensorMiddleFiltered, sensorRightFiltered} = filt_q;
  assign sample_tick = tick_q;
  assign changed = changed_q;
`ifdef LINE_LOST_EN
  localparam int LW = $clog2(LOST_TICKS + 1);
  localparam logic [LW-1:0] LMAX = LW'(LOST_TICKS);
  logic [LW-1:0] lost_q, lost_d;
  logic line_lost_q, line_lost_d;
  always_comb begin
    lost_d = lost_q;
    if (tick_q) lost_d = &filt_d ? (lost_q == LMAX ? lost_q : lost_q + 1'b1) : '0;
    line_lost_d = lost_d == LMAX;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lost_q <= '0;
      line_lost_q <= 1'b0;
    end else begin
      lost_q <= lost_d;
      line_lost_q <= line_lost_d;
    end
  end
  assign line_lost = line_lost_q;
`else
  assign line_lost = 1'b0;
`endif
endmodule

// File: tb/tb_sensor_filter.sv
// tb_sensor_filter: directed checks of sensor_filter with TICK_DIV=4, CNT_MAX=3, LOST_TICKS=5.
module tb_sensor_filter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] raw = 3'b000;
  logic lf, mf, rf, tick, chg, lost;
  logic [2:0] f;
  int checks = 0, failures = 0, n_chg = 0, n0 = 0;
`ifdef LINE_LOST_EN
  localparam logic LL = 1'b1;
`else
  localparam logic LL = 1'b0;
`endif
  sensor_filter #(.TICK_DIV(4), .CNT_MAX(3), .LOST_TICKS(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sensorLeftRaw(raw[2]),
    .sensorMiddleRaw(raw[1]),
    .sensorRightRaw(raw[0]),
    .sensorLeftFiltered(lf),
    .sensorMiddleFiltered(mf),
    .sensorRightFiltered(rf),
    .sample_tick(tick),
    .changed(chg),
    .line_lost(lost)
  );
  assign f = {lf, mf, rf};
  always #5 clk = ~clk;
  always @(negedge clk) if (chg) n_chg++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // advance to the next tick cycle, then one more negedge so its update is visible
  task automatic tick_update();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 20);
    if (!tick) chk("tick_timeout", tick, 1);
    @(negedge clk);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (10) @(negedge clk);
    chk("rst_filt", f, 3'b111);
    chk("rst_chg", chg, 0);
    chk("rst_tick", tick, 0);
    chk("rst_lost", lost, 0);
    raw = 3'b111;
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("tick_early", tick, 0);
    @(negedge clk);
    chk("tick_first", tick, 1);
    tick_update();
    raw = 3'b101;
    tick_update();
    chk("step_t1", f, 3'b111);
    tick_update();
    chk("step_t2", f, 3'b111);
    tick_update();
    chk("step_fall", f, 3'b101);
    chk("step_chg", chg, 1);
    @(negedge clk);
    chk("step_chg_one", chg, 0);
    chk("step_nchg", n_chg, 1);
    raw = 3'b111;
    repeat (2) tick_update();
    chk("rise_t2", f, 3'b101);
    tick_update();
    chk("rise", f, 3'b111);
    @(negedge clk);
    chk("rise_nchg", n_chg, 2);
    raw = 3'b101;
    tick_update();
    raw = 3'b111;
    tick_update();
    chk("glitch_filt", f, 3'b111);
    @(negedge clk);
    chk("glitch_nchg", n_chg, 2);
    raw = 3'b101;
    repeat (2) tick_update();
    chk("glitch_full_t2", f, 3'b111);
    tick_update();
    chk("glitch_full_fall", f, 3'b101);
    raw = 3'b111;
    repeat (3) tick_update();
    chk("glitch_restore", f, 3'b111);
    @(negedge clk);
    n0 = n_chg;
    for (int i = 0; i < 20; i++) begin
      raw = i % 2 ? 3'b111 : 3'b101;
      tick_update();
      chk("noise_filt", f, 3'b111);
    end
    @(negedge clk);
    chk("noise_nchg", n_chg, n0);
    raw = 3'b101;
    repeat (2) tick_update();
    chk("arst_pre", f, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_filt", f, 3'b111);
    chk("arst_chg", chg, 0);
    chk("arst_tick", tick, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) tick_update();
    chk("arst_cnt_t2", f, 3'b111);
    tick_update();
    chk("arst_cnt_fall", f, 3'b101);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mid0", f, 3'b111);
    raw = 3'b111;
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (4) tick_update();
    chk("lost_t4", lost, 0);
    tick_update();
    chk("lost_rise", lost, LL);
    raw = 3'b011;
    repeat (2) tick_update();
    chk("lost_hold", lost, LL);
    tick_update();
    chk("lost_left_fall", f, 3'b011);
    chk("lost_clear", lost, 0);
    @(negedge clk);
    n0 = n_chg;
    raw = 3'b000;
    repeat (3) tick_update();
    chk("simul_filt", f, 3'b000);
    chk("simul_chg", chg, 1);
    @(negedge clk);
    chk("simul_one_pulse", n_chg, n0 + 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
